// File: rtl/tx_replay_buffer.sv
// Transmit data link layer replay buffer: numbers outgoing TLPs, holds them until ACKed, replays on NAK.
// Optional replay timer (timeout-triggered replay) enabled by defining TX_REPLAY_TIMER_EN.
module tx_replay_buffer #(
  parameter int DATA_W         = 1024,
  parameter int DEPTH          = 4,
  parameter int REPLAY_TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      tlp_in_data,
  input  logic                   tlp_in_valid,
  output logic                   tlp_in_ready,
  output logic [DATA_W-1:0]      tx_tlp_data,
  output logic [11:0]            tx_tlp_seq,
  output logic                   tx_tlp_valid,
  input  logic                   tx_tlp_ready,
  input  logic [31:0]            dllp_in,
  input  logic                   dllp_in_valid,
  output logic                   dllp_err_o,
  output logic                   link_retrain_o,
  output logic [$clog2(DEPTH):0] unacked_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [7:0] TYPE_ACK = 8'h00;
  localparam logic [7:0] TYPE_NAK = 8'h10;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || REPLAY_TIMEOUT < 2) begin : g_bad_param
    $error("tx_replay_buffer: DEPTH must be a power of two in 2..64 and REPLAY_TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {NORMAL, REPLAY, LINK_DOWN} state_t;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [11:0]       seq_mem  [DEPTH];

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] send_ptr_reg, send_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [11:0]      next_seq_reg, next_seq_next;
  logic [11:0]      acked_seq_reg, acked_seq_next;
  logic [1:0]       replay_num_reg, replay_num_next;
  logic             link_retrain_reg, link_retrain_next;
  logic             dllp_err_reg;
  logic [PTR_W-1:0] unacked_cnt_reg;

  logic [PTR_W-1:0] held_cnt, sent_cnt, purge_cnt, rd_ptr_purged;
  logic [11:0]      ack_dist;
  logic [1:0]       replay_num_eff;
  logic             accept, send_hs, is_nak, dllp_live, ack_bad, ack_ok;
  logic             progress, timeout, trigger;
  logic             unused_dllp_bits;

  assign held_cnt     = wr_ptr_reg - rd_ptr_reg;
  assign sent_cnt     = send_ptr_reg - rd_ptr_reg;
  assign tlp_in_ready = (state_reg == NORMAL) && (held_cnt < PTR_W'(DEPTH));
  assign tx_tlp_valid = (send_ptr_reg != wr_ptr_reg) && (state_reg != LINK_DOWN);
  assign tx_tlp_data  = data_mem[send_ptr_reg[IDX_W-1:0]];
  assign tx_tlp_seq   = seq_mem[send_ptr_reg[IDX_W-1:0]];

  assign accept  = tlp_in_valid && tlp_in_ready;
  assign send_hs = tx_tlp_valid && tx_tlp_ready;

  // ACK/NAK distance is measured from the last acknowledged sequence number and
  // may only cover entries that have actually been put on the link.
  assign is_nak    = (dllp_in[31:24] == TYPE_NAK);
  assign dllp_live = dllp_in_valid && (state_reg != LINK_DOWN) &&
                     ((dllp_in[31:24] == TYPE_ACK) || is_nak);
  assign ack_dist  = dllp_in[11:0] - acked_seq_reg;
  assign ack_bad   = dllp_live && (ack_dist > 12'(sent_cnt));
  assign ack_ok    = dllp_live && !ack_bad;
  assign purge_cnt = ack_ok ? ack_dist[PTR_W-1:0] : '0;
  assign rd_ptr_purged = rd_ptr_reg + purge_cnt;
  assign progress  = (purge_cnt != '0);

  // Forward progress clears the replay count before a same-cycle NAK is counted.
  assign replay_num_eff = progress ? 2'd0 : replay_num_reg;
  assign trigger        = (ack_ok && is_nak) || timeout;

  assign unused_dllp_bits = ^dllp_in[23:12];

`ifdef TX_REPLAY_TIMER_EN
  localparam int TMR_W = $clog2(REPLAY_TIMEOUT);

  logic [TMR_W-1:0] timer_reg, timer_next;

  assign timeout = (timer_reg == TMR_W'(REPLAY_TIMEOUT - 1)) && (state_reg != LINK_DOWN);

  always_comb begin
    timer_next = '0;
    if (state_reg == LINK_DOWN) begin
      timer_next = timer_reg;
    end else if (trigger || progress) begin
      timer_next = '0;
    end else if (rd_ptr_reg != send_ptr_reg) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    wr_ptr_next       = wr_ptr_reg + PTR_W'(accept);
    rd_ptr_next       = rd_ptr_purged;
    send_ptr_next     = send_ptr_reg + PTR_W'(send_hs);
    next_seq_next     = next_seq_reg + 12'(accept);
    acked_seq_next    = ack_ok ? dllp_in[11:0] : acked_seq_reg;
    replay_num_next   = replay_num_eff;
    link_retrain_next = link_retrain_reg;
    state_next        = state_reg;
    if (trigger) begin
      if (replay_num_eff == 2'd3) begin
        state_next        = LINK_DOWN;
        link_retrain_next = 1'b1;
      end else begin
        // Rewind overrides any handshake in the same cycle.
        replay_num_next = replay_num_eff + 2'd1;
        send_ptr_next   = rd_ptr_purged;
        state_next      = REPLAY;
      end
    end else if ((state_reg == REPLAY) && (send_ptr_next == wr_ptr_next)) begin
      state_next = NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= NORMAL;
      wr_ptr_reg       <= '0;
      send_ptr_reg     <= '0;
      rd_ptr_reg       <= '0;
      next_seq_reg     <= '0;
      acked_seq_reg    <= 12'hFFF;
      replay_num_reg   <= '0;
      link_retrain_reg <= 1'b0;
      dllp_err_reg     <= 1'b0;
      unacked_cnt_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      wr_ptr_reg       <= wr_ptr_next;
      send_ptr_reg     <= send_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      next_seq_reg     <= next_seq_next;
      acked_seq_reg    <= acked_seq_next;
      replay_num_reg   <= replay_num_next;
      link_retrain_reg <= link_retrain_next;
      dllp_err_reg     <= ack_bad;
      unacked_cnt_reg  <= wr_ptr_next - rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr_reg[IDX_W-1:0]] <= tlp_in_data;
    end
  end

  // Sequence storage is cleared so the idle output shows sequence 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        seq_mem[i] <= '0;
      end
    end else if (accept) begin
      seq_mem[wr_ptr_reg[IDX_W-1:0]] <= next_seq_reg;
    end
  end

  assign dllp_err_o     = dllp_err_reg;
  assign link_retrain_o = link_retrain_reg;
  assign unacked_cnt_o  = unacked_cnt_reg;

endmodule

// File: tb/tb_tx_replay_buffer.sv
// Bench for tx_replay_buffer: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_tx_replay_buffer;
  localparam int DATA_W = 1024;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;
  localparam logic [7:0] ACK = 8'h00;
  localparam logic [7:0] NAK = 8'h10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [DATA_W-1:0]       tlp_in_data;
  logic                    tlp_in_valid;
  logic                    tlp_in_ready;
  logic [DATA_W-1:0]       tx_tlp_data;
  logic [11:0]             tx_tlp_seq;
  logic                    tx_tlp_valid;
  logic                    tx_tlp_ready;
  logic [31:0]             dllp_in;
  logic                    dllp_in_valid;
  logic                    dllp_err_o;
  logic                    link_retrain_o;
  logic [$clog2(DEPTH):0]  unacked_cnt_o;

  always #5 clk = ~clk;

  tx_replay_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REPLAY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .tlp_in_data(tlp_in_data), .tlp_in_valid(tlp_in_valid), .tlp_in_ready(tlp_in_ready),
    .tx_tlp_data(tx_tlp_data), .tx_tlp_seq(tx_tlp_seq), .tx_tlp_valid(tx_tlp_valid),
    .tx_tlp_ready(tx_tlp_ready), .dllp_in(dllp_in), .dllp_in_valid(dllp_in_valid),
    .dllp_err_o(dllp_err_o), .link_retrain_o(link_retrain_o), .unacked_cnt_o(unacked_cnt_o)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: held entries oldest-first, m_sent of them already on the link.
  logic [DATA_W-1:0] m_data [$];
  logic [11:0]       m_seq  [$];
  int                m_sent, m_mode, m_replay_num, m_timer;  // mode: 0 normal, 1 replay, 2 link down
  logic [11:0]       m_next_seq, m_acked;
  bit                m_err, m_retrain;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL tx_data: got ..%h expected ..%h at %0t", act[127:0], exp[127:0], $time);
    end
  endtask

  always @(posedge clk) begin
    logic [11:0] d;
    int n, rn, mode_old;
    bit ready, valid, acc, hs, progress, trig, outstanding;
    if (reset) begin
      m_data.delete(); m_seq.delete();
      m_sent = 0; m_mode = 0; m_replay_num = 0; m_timer = 0;
      m_next_seq = 12'd0; m_acked = 12'hFFF; m_err = 1'b0; m_retrain = 1'b0;
    end else begin
      mode_old    = m_mode;
      ready       = (m_mode == 0) && (m_seq.size() < DEPTH);
      valid       = (m_sent < m_seq.size()) && (m_mode != 2);
      acc         = tlp_in_valid && ready;
      hs          = valid && tx_tlp_ready;
      outstanding = (m_sent > 0);
      trig        = 1'b0;
`ifdef TX_REPLAY_TIMER_EN
      trig = (m_timer == TMO - 1) && (m_mode != 2);
`endif
      m_err = 1'b0;
      progress = 1'b0;
      if (dllp_in_valid && m_mode != 2 && (dllp_in[31:24] == ACK || dllp_in[31:24] == NAK)) begin
        d = dllp_in[11:0] - m_acked;
        n = int'(d);
        if (n > m_sent) begin
          m_err = 1'b1;
        end else begin
          repeat (n) begin
            void'(m_seq.pop_front());
            void'(m_data.pop_front());
          end
          m_sent  -= n;
          m_acked  = dllp_in[11:0];
          progress = (n > 0);
          if (dllp_in[31:24] == NAK) trig = 1'b1;
        end
      end
      if (hs) m_sent++;
      if (acc) begin
        m_seq.push_back(m_next_seq);
        m_data.push_back(tlp_in_data);
        m_next_seq++;
      end
      rn = progress ? 0 : m_replay_num;
      if (trig) begin
        if (rn == 3) begin
          m_mode = 2; m_retrain = 1'b1;
        end else begin
          m_replay_num = rn + 1; m_sent = 0; m_mode = 1;
        end
      end else begin
        m_replay_num = rn;
        if (m_mode == 1 && m_sent == m_seq.size()) m_mode = 0;
      end
      if (mode_old != 2) begin
        if (trig || progress || !outstanding) m_timer = 0;
        else m_timer++;
      end
    end
  end

  always @(negedge clk) begin
    bit e_ready, e_valid;
    if (chk_en) begin
      e_ready = (m_mode == 0) && (m_seq.size() < DEPTH);
      e_valid = (m_sent < m_seq.size()) && (m_mode != 2);
      check("in_ready", 64'(tlp_in_ready), 64'(e_ready));
      check("tx_valid", 64'(tx_tlp_valid), 64'(e_valid));
      if (e_valid && tx_tlp_valid) begin
        check("tx_seq", 64'(tx_tlp_seq), 64'(m_seq[m_sent]));
        check_data(tx_tlp_data, m_data[m_sent]);
      end
      check("dllp_err", 64'(dllp_err_o), 64'(m_err));
      check("retrain", 64'(link_retrain_o), 64'(m_retrain));
      check("unacked_cnt", 64'(unacked_cnt_o), 64'(m_seq.size()));
    end
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input bit v, input bit rdy, input bit dv, input logic [7:0] typ, input logic [11:0] sq);
    tlp_in_valid  = v;
    tlp_in_data   = rand_data();
    tx_tlp_ready  = rdy;
    dllp_in_valid = dv;
    dllp_in       = {typ, 12'($urandom), sq};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 8'h00, 12'h000);
    reset = 1'b0;
  endtask

  initial begin
    int beats;
    bit rst_now, dv, vin, rdy;
    logic [7:0] typ;
    logic [11:0] sq;

    reset = 1'b1;
    tlp_in_valid = 0; tlp_in_data = '0; tx_tlp_ready = 0; dllp_in_valid = 0; dllp_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", 64'(tlp_in_ready), 64'd1);
    check("rst_valid", 64'(tx_tlp_valid), 64'd0);
    check("rst_seq", 64'(tx_tlp_seq), 64'd0);
    check("rst_cnt", 64'(unacked_cnt_o), 64'd0);
    check("rst_err", 64'(dllp_err_o), 64'd0);
    check("rst_retrain", 64'(link_retrain_o), 64'd0);

    // Three TLPs back to back, then cumulative ACK.
    drive(1, 1, 0, ACK, 0); check("t1_seq0", 64'(tx_tlp_seq), 64'd0);
    drive(1, 1, 0, ACK, 0); check("t1_seq1", 64'(tx_tlp_seq), 64'd1);
    drive(1, 1, 0, ACK, 0); check("t1_seq2", 64'(tx_tlp_seq), 64'd2);
    drive(0, 1, 0, ACK, 0); check("t1_cnt3", 64'(unacked_cnt_o), 64'd3);
    drive(0, 1, 1, ACK, 2); check("t1_cnt0", 64'(unacked_cnt_o), 64'd0);

    // Full buffer backpressure released by ACK 0.
    do_reset();
    repeat (4) drive(1, 1, 0, ACK, 0);
    check("fill_ready0", 64'(tlp_in_ready), 64'd0);
    drive(1, 1, 0, ACK, 0);
    check("fill_held", 64'(unacked_cnt_o), 64'd4);
    drive(1, 1, 1, ACK, 0);
    check("fill_ready1", 64'(tlp_in_ready), 64'd1);
    check("fill_cnt3", 64'(unacked_cnt_o), 64'd3);

    // Out-of-range ACK.
    do_reset();
    drive(1, 1, 0, ACK, 0);
    drive(1, 1, 0, ACK, 0);
    drive(0, 1, 0, ACK, 0);
    drive(0, 1, 1, ACK, 5);
    check("err_pulse", 64'(dllp_err_o), 64'd1);
    check("err_cnt", 64'(unacked_cnt_o), 64'd2);
    drive(0, 1, 0, ACK, 0);
    check("err_clear", 64'(dllp_err_o), 64'd0);

    // NAK 1 after seq 0..3: seq 2,3 replayed, input blocked until done.
    do_reset();
    repeat (4) drive(1, 1, 0, ACK, 0);
    drive(0, 1, 0, ACK, 0);
    drive(0, 1, 1, NAK, 1);
    check("nak_seq2", 64'(tx_tlp_seq), 64'd2);
    check("nak_block", 64'(tlp_in_ready), 64'd0);
    drive(0, 1, 0, ACK, 0);
    check("nak_seq3", 64'(tx_tlp_seq), 64'd3);
    check("nak_block2", 64'(tlp_in_ready), 64'd0);
    drive(0, 1, 0, ACK, 0);
    check("nak_done_ready", 64'(tlp_in_ready), 64'd1);
    check("nak_done_valid", 64'(tx_tlp_valid), 64'd0);

    // Reset while replaying.
    drive(0, 0, 1, NAK, 1);
    check("rr_in_replay", 64'(tlp_in_ready), 64'd0);
    do_reset();
    check("rr_valid", 64'(tx_tlp_valid), 64'd0);
    check("rr_cnt", 64'(unacked_cnt_o), 64'd0);
    drive(1, 1, 0, ACK, 0);
    check("rr_seq0", 64'(tx_tlp_seq), 64'd0);

`ifdef TX_REPLAY_TIMER_EN
    // Timeout replays until the fourth trigger brings the link down.
    do_reset();
    drive(1, 1, 0, ACK, 0);
    beats = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx_tlp_valid) beats++;
      drive(0, 1, 0, ACK, 0);
    end
    check("tmr_beats", 64'(beats), 64'd4);
    check("tmr_retrain", 64'(link_retrain_o), 64'd1);
    check("tmr_valid", 64'(tx_tlp_valid), 64'd0);
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_now = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
      vin = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 75 : 25));
      dv  = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 99)) inside
        [0:54]:  typ = ACK;
        [55:79]: typ = NAK;
        default: typ = 8'h20 + 8'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 99) < 85) sq = m_acked + 12'($urandom_range(0, m_sent + 1));
      else sq = 12'($urandom_range(0, 4095));
      reset = rst_now;
      drive(vin, rdy, dv, typ, sq);
    end
    reset = 1'b0;
    drive(0, 0, 0, ACK, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
